// File: rtl/lvds_rx_pkg.sv
// lvds_rx_pkg: shared types and constants for the LVDS receive phase calibrator.
//   cal_state_t  - calibration FSM state encoding
//   DUTYDA_VAL / FDLY_VAL - fixed rPLL duty-cycle and fine-delay settings
//   RETRY_LIMIT  - lock attempts before giving up
//   run_center() - centre phase of a circular pass run
package lvds_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_READY,
        ST_FAIL
    } cal_state_t;

    localparam logic [3:0] DUTYDA_VAL  = 4'b1000;
    localparam logic [3:0] FDLY_VAL    = 4'b0000;
    localparam int         RETRY_LIMIT = 3;

    // (start + (len-1)/2) mod 16; the 4-bit sum provides the wrap.
    function automatic logic [3:0] run_center(input logic [3:0] start, input logic [4:0] len);
        return start + 4'((len - 5'd1) >> 1);
    endfunction

endpackage

// File: rtl/lvds_sync2.sv
// lvds_sync2: two-flop synchronizer for a single asynchronous level.
//   clk, rst_n - destination clock and async active-low reset
//   d          - asynchronous input
//   q          - synchronized output (reset value 0)
module lvds_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lvds_rx_phase_cal.sv
// lvds_rx_phase_cal: resets the rPLL, waits for lock, sweeps all 16 dynamic
// phases checking the deserializer training word, then parks psda at the
// centre of the longest circular run of passing phases.
//   clk, rst_n   - clock, async active-low reset
//   start        - level request to (re)calibrate from IDLE or FAIL
//   pll_lock     - rPLL lock (asynchronous)
//   pattern_ok   - training-word match, valid every cycle
//   pll_reset    - active-high rPLL reset
//   psda         - rPLL phase select; dutyda/fdly are constants
//   rx_ready     - calibrated and locked
//   cal_fail     - calibration or lock failed
//   pass_mask    - per-phase pass result of the last sweep
//   lock_lost    - one-cycle pulse on lock loss in READY
module lvds_rx_phase_cal
    import lvds_rx_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 64,
    parameter int SAMPLE_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pll_lock,
    input  logic        pattern_ok,
    output logic        pll_reset,
    output logic [3:0]  psda,
    output logic [3:0]  dutyda,
    output logic [3:0]  fdly,
    output logic        rx_ready,
    output logic        cal_fail,
    output logic [15:0] pass_mask,
    output logic        lock_lost
);

    // The counter also indexes the 32-step EVAL scan, so it must reach 31.
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > 32) ? MAX_C : 32;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    cal_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        retry;
    logic              lock;
    logic              sample_ok;
    logic [4:0]        run_len, run_len_n, best_len, best_len_n;
    logic [3:0]        run_start, run_start_n, best_start, best_start_n;

    lvds_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock)
    );

    logic rst_done, lock_to, settle_done, sample_done, eval_last, retry_last, eval_bit;
    assign rst_done    = (cnt == CNT_W'(RST_CYCLES - 1));
    assign lock_to     = (cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign sample_done = (cnt == CNT_W'(SAMPLE_CYCLES - 1));
    assign eval_last   = (cnt == CNT_W'(31));
    assign retry_last  = (retry == 2'(RETRY_LIMIT - 1));
    assign eval_bit    = pass_mask[cnt[3:0]];

    // Run tracker for the EVAL scan; only strictly longer runs replace the
    // best, so equal-length runs keep the earliest start.
    always_comb begin
        run_len_n    = 5'd0;
        run_start_n  = run_start;
        best_len_n   = best_len;
        best_start_n = best_start;
        if (eval_bit) begin
            run_start_n = (run_len == 5'd0) ? cnt[3:0] : run_start;
            run_len_n   = (run_len == 5'd16) ? 5'd16 : run_len + 5'd1;
            if (run_len_n > best_len) begin
                best_len_n   = run_len_n;
                best_start_n = run_start_n;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:      if (start) state_n = ST_PLL_RST;
            ST_PLL_RST:   if (rst_done) state_n = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock)         state_n = ST_SETTLE;
                else if (lock_to) state_n = retry_last ? ST_FAIL : ST_PLL_RST;
            end
            ST_SETTLE: begin
                if (!lock)            state_n = ST_PLL_RST;
                else if (settle_done) state_n = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!lock)            state_n = ST_PLL_RST;
                else if (sample_done) state_n = (psda == 4'd15) ? ST_EVAL : ST_SETTLE;
            end
            ST_EVAL:      if (eval_last) state_n = (best_len_n == 5'd0) ? ST_FAIL : ST_READY;
            ST_READY:     if (!lock) state_n = ST_PLL_RST;
            ST_FAIL:      if (start) state_n = ST_PLL_RST;
            default:      state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    logic counting;
    assign counting = (state == ST_PLL_RST) || (state == ST_WAIT_LOCK) || (state == ST_SETTLE)
                   || (state == ST_SAMPLE) || (state == ST_EVAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset  <= 1'b1;
            cnt        <= '0;
            retry      <= '0;
            psda       <= '0;
            pass_mask  <= '0;
            sample_ok  <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else begin
            // Registered from next state so the pulse aligns exactly with PLL_RST.
            pll_reset <= (state_n == ST_PLL_RST);
            cnt       <= (counting && state_n == state) ? cnt + CNT_W'(1) : '0;
            case (state)
                ST_WAIT_LOCK: begin
                    if (lock) begin
                        psda      <= '0;
                        pass_mask <= '0;
                        retry     <= '0;
                    end else if (lock_to) begin
                        retry <= retry_last ? 2'd0 : retry + 2'd1;
                    end
                end
                ST_SETTLE: begin
                    sample_ok  <= 1'b1;
                    run_len    <= '0;
                    run_start  <= '0;
                    best_len   <= '0;
                    best_start <= '0;
                end
                ST_SAMPLE: begin
                    if (lock) begin
                        sample_ok <= sample_ok & pattern_ok;
                        if (sample_done) begin
                            pass_mask[psda] <= sample_ok & pattern_ok;
                            if (psda != 4'd15) psda <= psda + 4'd1;
                        end
                    end
                end
                ST_EVAL: begin
                    run_len    <= run_len_n;
                    run_start  <= run_start_n;
                    best_len   <= best_len_n;
                    best_start <= best_start_n;
                    if (eval_last && best_len_n != 5'd0)
                        psda <= run_center(best_start_n, best_len_n);
                end
                default: ;
            endcase
        end
    end

    assign dutyda    = DUTYDA_VAL;
    assign fdly      = FDLY_VAL;
    assign rx_ready  = (state == ST_READY) && lock;
    assign lock_lost = (state == ST_READY) && !lock;
    assign cal_fail  = (state == ST_FAIL);

endmodule

// File: tb/tb_lvds_rx_phase_cal.sv
module tb_lvds_rx_phase_cal;

    typedef struct packed {
        logic [15:0] mask;
        logic [3:0]  psda;
        logic        ready;
        logic        fail;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pll_lock = 1'b0;
    logic        pattern_ok;
    logic        pll_reset;
    logic [3:0]  psda, dutyda, fdly;
    logic        rx_ready, cal_fail, lock_lost;
    logic [15:0] pass_mask;

    logic [15:0] tb_mask = 16'h0000;
    logic        glitch_en = 1'b0;
    logic        tog = 1'b0;
    int          checks = 0;
    int          errors = 0;
    res_t        exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    // Deserializer model: phases in tb_mask match; phase 10 flickers when glitch_en.
    assign pattern_ok = tb_mask[psda] & ~(glitch_en && psda == 4'd10 && tog);

    lvds_rx_phase_cal #(
        .RST_CYCLES(16), .LOCK_TIMEOUT(40), .SETTLE_CYCLES(4), .SAMPLE_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pll_lock(pll_lock),
        .pattern_ok(pattern_ok), .pll_reset(pll_reset), .psda(psda),
        .dutyda(dutyda), .fdly(fdly), .rx_ready(rx_ready), .cal_fail(cal_fail),
        .pass_mask(pass_mask), .lock_lost(lock_lost)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_cal();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output res_t got, output bit hit);
        hit = 1'b0;
        got = '0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (rx_ready || cal_fail) begin
                hit = 1'b1;
                got = '{pass_mask, cal_fail ? 4'd0 : psda, rx_ready, cal_fail};
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pll_reset, psda, rx_ready, cal_fail, lock_lost, pass_mask} !== {1'b1, 4'd0, 3'b000, 16'h0}) begin
            errors++;
            $display("FAIL reset_outputs got rst=%b psda=%0d rdy=%b fail=%b lost=%b mask=%h",
                     pll_reset, psda, rx_ready, cal_fail, lock_lost, pass_mask);
        end
        checks++;
        if (dutyda !== 4'b1000 || fdly !== 4'b0000) begin
            errors++;
            $display("FAIL constants got dutyda=%b fdly=%b want 1000 0000", dutyda, fdly);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pll_reset !== 1'b0 || rx_ready !== 1'b0 || cal_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got pll_reset=%b rdy=%b fail=%b want 0 0 0", pll_reset, rx_ready, cal_fail);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (pll_reset !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got pll_reset=%b want 0", pll_reset);
        end
    endtask

    task automatic test_center();
        res_t got, e;
        bit   hit;
        do_reset();
        pll_lock = 1'b1;
        tb_mask = 16'h07E0;
        glitch_en = 1'b1;
        exp_q.push_back('{16'h03E0, 4'd7, 1'b1, 1'b0});
        start_cal();
        wait_done(got, hit);
        e = exp_q.pop_front();
        checks++;
        if (!hit || got !== e) begin
            errors++;
            $display("FAIL center hit=%b got mask=%h psda=%0d rdy=%b fail=%b want mask=%h psda=%0d",
                     hit, got.mask, got.psda, got.ready, got.fail, e.mask, e.psda);
        end
        glitch_en = 1'b0;
    endtask

    task automatic test_lock_loss();
        res_t got, e;
        bit   hit;
        int   lost_cnt = 0;
        bit   saw_rst = 0;
        bit   bad_rdy = 0;
        tb_mask = 16'hC003;
        exp_q.push_back('{16'hC003, 4'd15, 1'b1, 1'b0});
        @(negedge clk) pll_lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) pll_lock = 1'b1;
            if (lock_lost) begin
                lost_cnt++;
                if (rx_ready) bad_rdy = 1;
            end
            if (pll_reset) saw_rst = 1;
        end
        checks++;
        if (lost_cnt != 1 || bad_rdy) begin
            errors++;
            $display("FAIL lock_lost_pulse got cycles=%0d rdy_with_lost=%b want 1 0", lost_cnt, bad_rdy);
        end
        checks++;
        if (!saw_rst) begin
            errors++;
            $display("FAIL lock_loss_pll_reset got no pll_reset pulse want one");
        end
        wait_done(got, hit);
        e = exp_q.pop_front();
        checks++;
        if (!hit || got !== e) begin
            errors++;
            $display("FAIL wrap_resweep hit=%b got mask=%h psda=%0d want mask=%h psda=%0d",
                     hit, got.mask, got.psda, e.mask, e.psda);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] pat [3] = '{16'hFFFF, 16'h0000, 16'h0C0C};
        res_t        want [3];
        res_t        got, e;
        bit          hit;
        want[0] = '{16'hFFFF, 4'd7, 1'b1, 1'b0};
        want[1] = '{16'h0000, 4'd0, 1'b0, 1'b1};
        want[2] = '{16'h0C0C, 4'd2, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            pll_lock = 1'b1;
            tb_mask = pat[k];
            exp_q.push_back(want[k]);
            start_cal();
            wait_done(got, hit);
            e = exp_q.pop_front();
            checks++;
            if (!hit || got !== e) begin
                errors++;
                $display("FAIL pattern_%0d hit=%b got mask=%h psda=%0d rdy=%b fail=%b want mask=%h psda=%0d rdy=%b fail=%b",
                         k, hit, got.mask, got.psda, got.ready, got.fail, e.mask, e.psda, e.ready, e.fail);
            end
        end
    endtask

    task automatic test_no_lock();
        res_t got, e;
        bit   hit;
        int   pulses = 0, bad_w = 0, cur_w = 0;
        bit   done = 0;
        do_reset();
        pll_lock = 1'b0;
        tb_mask = 16'h03E0;
        exp_q.push_back('{16'h0000, 4'd0, 1'b0, 1'b1});
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (pll_reset) cur_w++;
            else if (cur_w != 0) begin
                pulses++;
                if (cur_w != 16) bad_w++;
                cur_w = 0;
            end
            if (cal_fail) done = 1;
            start = (i == 0);
        end
        got = '{pass_mask, 4'd0, rx_ready, cal_fail};
        e = exp_q.pop_front();
        checks++;
        if (!done || got !== e) begin
            errors++;
            $display("FAIL no_lock_fail done=%b got mask=%h rdy=%b fail=%b want fail=1 rdy=0", done, got.mask, got.ready, got.fail);
        end
        checks++;
        if (pulses != 3 || bad_w != 0) begin
            errors++;
            $display("FAIL no_lock_pulses got pulses=%0d bad_width=%0d want 3 0", pulses, bad_w);
        end
        pll_lock = 1'b1;
        exp_q.push_back('{16'h03E0, 4'd7, 1'b1, 1'b0});
        start_cal();
        wait_done(got, hit);
        e = exp_q.pop_front();
        checks++;
        if (!hit || got !== e) begin
            errors++;
            $display("FAIL fail_recover hit=%b got mask=%h psda=%0d fail=%b want mask=%h psda=%0d fail=0",
                     hit, got.mask, got.psda, got.fail, e.mask, e.psda);
        end
    endtask

    task automatic test_lock_drop_sweep();
        res_t got, e;
        bit   hit, at4 = 0, saw_rst = 0;
        do_reset();
        pll_lock = 1'b1;
        tb_mask = 16'h03E0;
        exp_q.push_back('{16'h03E0, 4'd7, 1'b1, 1'b0});
        start_cal();
        for (int i = 0; i < 1000 && !at4; i++) begin
            @(negedge clk);
            if (psda == 4'd4) at4 = 1;
        end
        repeat (6) @(negedge clk);
        pll_lock = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) pll_lock = 1'b1;
            if (pll_reset) saw_rst = 1;
        end
        checks++;
        if (!at4 || !saw_rst) begin
            errors++;
            $display("FAIL sweep_lock_drop got reached_p4=%b pll_reset=%b want 1 1", at4, saw_rst);
        end
        wait_done(got, hit);
        e = exp_q.pop_front();
        checks++;
        if (!hit || got !== e) begin
            errors++;
            $display("FAIL sweep_restart hit=%b got mask=%h psda=%0d want mask=%h psda=%0d",
                     hit, got.mask, got.psda, e.mask, e.psda);
        end
    endtask

    task automatic test_reset_mid();
        bit at5 = 0, resumed = 0;
        do_reset();
        pll_lock = 1'b1;
        tb_mask = 16'hFFFF;
        start_cal();
        for (int i = 0; i < 1000 && !at5; i++) begin
            @(negedge clk);
            if (psda == 4'd5) at5 = 1;
        end
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!at5 || {pll_reset, psda, rx_ready, cal_fail, lock_lost, pass_mask} !== {1'b1, 4'd0, 3'b000, 16'h0}) begin
            errors++;
            $display("FAIL reset_mid reached=%b got rst=%b psda=%0d rdy=%b fail=%b lost=%b mask=%h",
                     at5, pll_reset, psda, rx_ready, cal_fail, lock_lost, pass_mask);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pll_reset || rx_ready || cal_fail) resumed = 1;
        end
        checks++;
        if (resumed) begin
            errors++;
            $display("FAIL reset_no_resume got activity after reset want idle");
        end
    endtask

    initial begin
        test_reset();
        test_center();
        test_lock_loss();
        test_patterns();
        test_no_lock();
        test_lock_drop_sweep();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
